// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, encodings and helpers for the multiply/divide unit.
//   XLEN      default operand width (HI and LO are each XLEN bits)
//   DWIDTH    double width; also the width of cond_neg's argument
//   ITER_LAST index of the last RUN iteration at the default width
//   op_e      MULT/MULTU/DIV/DIVU encodings as seen on the op port
//   state_e   controller states
//   cond_neg  conditional two's-complement negate (operand abs and result fix-up)
package muldiv_pkg;

    localparam int XLEN      = 32;
    localparam int DWIDTH    = 2 * XLEN;
    localparam int ITER_LAST = XLEN - 1;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

    // Works for any value up to DWIDTH bits: the low bits of a negated
    // zero-extended value equal the negation at the narrower width.
    function automatic logic [DWIDTH-1:0] cond_neg(input logic [DWIDTH-1:0] x,
                                                   input logic              neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: iteration engine shared by multiply and divide.
//   clk, rst_n   clock and synchronous active-low reset
//   load         capture magnitudes a/b and the mode for a new operation
//   step         perform one iteration (one per cycle while the FSM is in RUN)
//   div_mode     at load: 1 = restoring divide, 0 = shift-add multiply
//   a, b         operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   acc_hi/lo    accumulator halves: product {hi,lo}, or remainder/quotient
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;    // multiplicand (multiply) or divisor (divide)
    logic               mode;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] acc_next;

    // NOTE: combinational logic uses blocking '=' with every output assigned on
    // every path, so nothing here can infer a latch; state below uses '<='.
    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift the whole thing right.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: shift {rem, quo} left and trial-subtract the divisor from
        // the remainder, including the bit shifted out of the top.
        shifted = {acc[2*WIDTH-2:0], 1'b0};
        trial   = {acc[2*WIDTH-1], shifted[2*WIDTH-1:WIDTH]} - {1'b0, opnd};
        if (!mode)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else if (!trial[WIDTH])
            acc_next = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        else
            acc_next = shifted;   // restore: keep the unsubtracted remainder
    end

    // NOTE: reset is synchronous, sampled at the clock edge like any other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            opnd <= '0;
            mode <= 1'b0;
        end else if (load) begin
            mode <= div_mode;
            acc  <= {{WIDTH{1'b0}}, (div_mode ? a : b)};
            opnd <= div_mode ? b : a;
        end else if (step) begin
            acc <= acc_next;
        end
    end

    assign acc_hi = acc[2*WIDTH-1:WIDTH];
    assign acc_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
//   clk, rst_n    clock and synchronous active-low reset
//   start, op     begin an operation (sampled only in IDLE); op selects the kind
//   in1, in2      rs / rt operands, captured at the start edge
//   hi_we, lo_we  MTHI/MTLO strobes with wdata, honoured only in IDLE
//   busy          operation in progress (controller stalls the PC)
//   done          one-cycle pulse when hi/lo hold a new result
//   div_by_zero   valid with done, held until the next start
//   hi, lo        architectural HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int DW = 2 * WIDTH;
    // The package constant tracks the default width; shift it for narrower instances.
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER_LAST - (XLEN - WIDTH));

    state_e           state;
    op_e              op_r;
    logic [CW-1:0]    count;
    logic             neg_q;     // negate product / quotient
    logic             neg_r;     // negate remainder (dividend was negative)
    logic             dz;
    logic [WIDTH-1:0] in1_raw;   // original dividend, returned in HI on divide by zero

    logic             signed_op, div_op, load;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        div_op    = (op == OP_DIV)  || (op == OP_DIVU);
        load      = (state == IDLE) && start;
        a_mag     = WIDTH'(cond_neg(DWIDTH'(in1), signed_op && in1[WIDTH-1]));
        b_mag     = WIDTH'(cond_neg(DWIDTH'(in2), signed_op && in2[WIDTH-1]));
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (state == RUN),
        .div_mode (div_op),
        .a        (a_mag),
        .b        (b_mag),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo)
    );

    // Sign fix-up, evaluated during FINISH and registered on the way out.
    always_comb begin
        prod = DW'(cond_neg(DWIDTH'({acc_hi, acc_lo}), neg_q));
        quo  = WIDTH'(cond_neg(DWIDTH'(acc_lo), neg_q));
        rem  = WIDTH'(cond_neg(DWIDTH'(acc_hi), neg_r));
        if (!(op_r == OP_DIV || op_r == OP_DIVU)) begin
            res_hi = prod[DW-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (dz) begin
            res_hi = in1_raw;
            res_lo = '1;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_r        <= OP_MULT;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            in1_raw     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        op_r        <= op_e'(op);
                        count       <= '0;
                        neg_q       <= signed_op && (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        neg_r       <= signed_op && in1[WIDTH-1];
                        dz          <= div_op && (in2 == '0);
                        in1_raw     <= in1;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == LAST_ITER) state <= FINISH;
                end
                FINISH: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    div_by_zero <= dz;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Expected results are
// pushed to a queue when an operation is started and popped by a monitor
// whenever the DUT pulses done.
module tb_muldiv_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] in1, in2;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    res_t sb_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model built on the simulator's own 64-bit arithmetic.
    function automatic res_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t        r;
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.dz = 1'b0;
        case (o)
            2'b00: begin p = 64'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    r.lo = '1; r.hi = a; r.dz = 1'b1;
                end else if (o == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        r.lo = 32'h8000_0000; r.hi = 0;
                    end else begin
                        r.lo = 32'(sa / sb); r.hi = 32'(sa % sb);
                    end
                end else begin
                    r.lo = a / b; r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (mon_en && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, e.hi});
                check("result_lo", {32'd0, lo}, {32'd0, e.lo});
                check("result_dz", {63'd0, div_by_zero}, {63'd0, e.dz});
            end
        end
    end

    // Start one operation, track busy/done timing, optionally disturb it mid-run.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input res_t exp, input bit disturb);
        int k;
        bit busy_ok;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk);                       // edge 0
        #1;
        start = 1'b0; in1 = $urandom; in2 = $urandom;  // must not affect the result
        busy_ok = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);                   // sample after edge k
            if (done === 1'b1 || k >= 100) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (disturb && k == 9) begin
                start = 1'b1; op = 2'b10; in1 = 32'h1111_1111; in2 = 32'h7;
                hi_we = 1'b1; wdata = 32'h0000_DEAD;
            end
            if (disturb && k == 10) begin
                start = 1'b0; hi_we = 1'b0;
            end
            k++;
        end
        check("done_latency", 64'(k), 64'd33);
        check("busy_during_run", {63'd0, busy_ok}, 64'd1);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        res_t e;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dz", {63'd0, div_by_zero}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFF, 32'h2, '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0}, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h2, '{32'h0000_0001, 32'hFFFF_FFFE, 1'b0}, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}, 1'b0);
        run_op(2'b11, 32'h7, 32'h0, '{32'h0000_0007, 32'hFFFF_FFFF, 1'b1}, 1'b0);
        repeat (3) @(negedge clk);
        check("dz_held", {63'd0, div_by_zero}, 64'd1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0, 32'h8000_0000, 1'b0}, 1'b0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, '{32'hF, 32'h0FFF_FFFF, 1'b0}, 1'b0);
        run_op(2'b01, 32'd3, 32'd5, '{32'h0, 32'd15, 1'b0}, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (i == 0) begin o = 2'b10; a = 32'h8000_0001; b = 32'h3; end
            e = model(o, a, b);
            run_op(o, a, b, e, 1'b0);
        end

        // MTLO in IDLE, then reset in the middle of a MULT.
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", {32'd0, lo}, 64'h1234);
        start = 1'b1; op = 2'b00; in1 = 32'h55; in2 = 32'h66;
        @(posedge clk);                       // edge 0
        #1 start = 1'b0;
        repeat (11) @(posedge clk);           // edges 1..11
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);                       // edge 12
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        begin
            bit saw_done = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done === 1'b1) saw_done = 1'b1;
            end
            check("no_done_after_rst", {63'd0, saw_done}, 64'd0);
        end

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the main ALU. Takes the same two register-file operands (in1 = rs, in2 = rt) and implements MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers. Their outputs feed the writeback mux for MFHI/MFLO.
- Runs multi-cycle. The controller stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- in1  in  WIDTH  multiplicand / dividend (rs)
- in2  in  WIDTH  multiplier / divisor (rt)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; HI/LO hold the new result
- div_by_zero  out  1  valid with done; set when a DIV/DIVU had in2 = 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: rst_n = 0 at a rising edge forces state IDLE and clears busy, done, div_by_zero, hi, lo and all internal registers to 0. This holds at any time, including mid-operation; an interrupted result is discarded.
- States:
  - IDLE: on start, latch op. Latch |in1| and |in2| for signed ops, raw values otherwise. Record the result signs, clear count, go to RUN.
  - RUN: one iteration per cycle, count 0..31. Multiply uses shift-add into a 2*WIDTH accumulator. Divide uses restoring division, one quotient bit per cycle. After the count = 31 iteration, go to FINISH.
  - FINISH: apply sign fix-up. At the next edge: register hi/lo, done = 1, div_by_zero as computed, go to IDLE.
- Timing, with start sampled at edge 0:
  - busy = 1 after edges 0..32.
  - Result registered at edge 33. After edge 33: hi/lo show the result, done = 1, busy = 0.
  - done falls after edge 34. div_by_zero holds until the next start.
- Multiply: {hi, lo} = full 64-bit product. Two's-complement for MULT, unsigned for MULTU.
- Divide:
  - lo = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero: still full latency. lo = all ones, hi = in1 as latched (original signed value), div_by_zero = 1.
  - Signed overflow, 0x80000000 / -1: lo = 0x80000000, hi = 0. No flag.
- Operand capture: in1/in2 are captured at the start edge; later changes have no effect.
- start while busy (RUN/FINISH): ignored, with no queueing.
- hi_we/lo_we:
  - Honoured only in IDLE: register wdata at the edge.
  - Ignored while busy; the controller must not issue them then.
- Simultaneous start and hi_we/lo_we in IDLE: the write takes effect at that edge, and the operation's result overwrites it at completion.
- op = DIV/DIVU with start and in2 = 0: div_by_zero is known at capture but is reported only with done.
- No X on outputs after reset. hi/lo change only on reset, an IDLE write, or completion.

Decomposition:
- Package muldiv_pkg:
  - WIDTH default
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum: IDLE, RUN, FINISH
  - ITER_LAST = WIDTH-1
  - function for conditional two's-complement negate, used for operand abs and result fix-up
- One sub-module is natural: muldiv_datapath. It holds the accumulator/remainder shift registers and the per-cycle add/subtract step.
- The top keeps the FSM, counter, HI/LO and handshake.

Test Plan:
- MULT in1 = 0xFFFFFFFF, in2 = 0x00000002 → after edge 33: hi = 0xFFFFFFFF, lo = 0xFFFFFFFE, done = 1 for exactly one cycle, busy high for cycles 1..33.
- MULTU same operands → hi = 0x00000001, lo = 0xFFFFFFFE.
- DIV in1 = 0xFFFFFFF9 (-7), in2 = 2 → lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). Then DIVU 7 / 0 → lo = 0xFFFFFFFF, hi = 0x00000007, div_by_zero = 1.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, div_by_zero = 0. Then DIVU 0xFFFFFFFF / 0x10 → lo = 0x0FFFFFFF, hi = 0xF.
- Start MULTU 3 × 5; pulse start with different operands and hi_we with wdata = 0xDEAD at cycle 10 → both ignored; result hi = 0, lo = 15 at edge 33.
- In IDLE, lo_we with wdata = 0x1234 → lo = 0x1234 next cycle. Start MULT; drive rst_n = 0 at edge 12 → busy = 0, done = 0, hi = lo = 0 after that edge; no done pulse follows.
